ysyx_24110015_axi_sram_slave: RTL and testbench

AXI4 slave responder backed by an internal word-addressed SRAM. It is the far end of the AXI4 master bus that the core drives through its arbiter and crossbar. It is used as a bench memory model behind the core's master port, and as the responder that will service the SoC-facing slave port. It handles one read burst and one write burst concurrently, with independent FSMs, a configurable read latency and byte-strobed writes.

---
 rtl/ysyx_24110015_axi_sram_slave.sv | 218 +++++++++++++++++++++
 tb/tb_ysyx_24110015_axi_sram_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_axi_sram_slave.sv
// AXI4 slave over a word-addressed SRAM: independent read/write FSMs, byte-strobed writes.
// First rvalid READ_LATENCY+2 cycles after AR handshake; R/B outputs hold until rready/bready.
module ysyx_24110015_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0f00_0000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int          IW          = $clog2(DEPTH_WORDS);
  localparam int          CW          = $clog2(READ_LATENCY + 2);
  localparam logic [31:0] SPAN        = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_LOAD, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH_WORDS];

  // WRAP/reserved bursts, oversize beats and out-of-window addresses never touch the SRAM.
  function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return burst[1] || (size > 3'd2) || (off >= SPAN);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
    return IW'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
  endfunction

  // ---------------- write side ----------------
  wstate_t     w_state;
  burst_t      w_cur;
  logic [7:0]  w_beat;
  logic        w_err;
  logic        w_fire;
  logic        w_beat_err;
  logic        w_last_beat;
  logic        w_commit;

  always_comb begin
    w_fire      = (w_state == W_DATA) && wvalid && wready;
    w_beat_err  = beat_err(w_cur.addr, w_cur.size, w_cur.burst);
    w_last_beat = (w_beat == w_cur.len);
    w_commit    = rst_n && w_fire && !w_beat_err;
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx(w_cur.addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_cur   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_cur   <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            // A misplaced wlast only poisons the response; the beat count still ends the burst.
            w_err <= w_err || w_beat_err || (wlast != w_last_beat);
            if (w_last_beat) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_cur.id;
              bresp   <= (w_err || w_beat_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_beat     <= w_beat + 8'd1;
              w_cur.addr <= next_addr(w_cur.addr, w_cur.size, w_cur.burst);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read side ----------------
  rstate_t     r_state;
  burst_t      r_cur;
  logic [7:0]  r_beat;
  logic [CW-1:0] r_cnt;
  logic        r_beat_err;

  always_comb r_beat_err = beat_err(r_cur.addr, r_cur.size, r_cur.burst);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_cur   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      rid     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_cur   <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
            r_beat  <= '0;
            r_cnt   <= CW'(READ_LATENCY);
            arready <= 1'b0;
            r_state <= (READ_LATENCY == 0) ? R_LOAD : R_WAIT;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) r_state <= R_LOAD;
        end
        R_LOAD: begin
          // Sampled from the pre-edge array, so a same-cycle write is not seen here.
          rdata   <= r_beat_err ? 32'h0 : mem[word_idx(r_cur.addr)];
          rresp   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
          rlast   <= (r_beat == r_cur.len);
          rid     <= r_cur.id;
          rvalid  <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_beat     <= r_beat + 8'd1;
              r_cur.addr <= next_addr(r_cur.addr, r_cur.size, r_cur.burst);
              r_state    <= R_LOAD;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_sram_slave.sv
// Directed bench for the AXI SRAM slave: reset, strobes, bursts, error responses, concurrency.
module tb_ysyx_24110015_axi_sram_slave;

  localparam int TMO     = 60;
  localparam int LAT_EXP = 4;  // READ_LATENCY(2) + 2

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rd_dat [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id [16];

  ysyx_24110015_axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1. bad_last flips wlast on that beat index.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int bad_last,
                          output logic [1:0] resp, output logic [3:0] resp_id);
    int n;
    awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < TMO);
    chk("aw_ready", 32'(awready), 32'h1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b];
      wlast = (b == int'(len)) ^ (b == bad_last);
      wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < TMO);
      chk("w_ready", 32'(wready), 32'h1);
      @(posedge clk); #1 wvalid = 1'b0;
    end
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < TMO);
    chk("b_valid", 32'(bvalid), 32'h1);
    resp = bresp; resp_id = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  // toggle=1 flips rready on every cycle rvalid is seen, starting from rready=1.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic toggle, output int lat);
    int n, cyc, beat;
    logic stalled;
    logic [31:0] held;
    araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < TMO);
    chk("ar_ready", 32'(arready), 32'h1);
    @(posedge clk); #1 arvalid = 1'b0;
    cyc = 0; beat = 0; lat = -1; stalled = 1'b0; held = '0;
    while (beat <= int'(len) && cyc < 4 * TMO) begin
      @(negedge clk); cyc++;
      if (rvalid) begin
        if (lat < 0) lat = cyc;
        if (stalled) chk("r_hold", rdata, held);
        if (rready) begin
          rd_dat[beat] = rdata; rd_resp[beat] = rresp; rd_last[beat] = rlast; rd_id[beat] = rid;
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = rdata;
        end
      end
      @(posedge clk); #1;
      if (toggle && rvalid) rready = !rready;
    end
    chk("r_beats", 32'(beat), 32'(int'(len) + 1));
    rready = 1'b0;
  endtask

  logic [1:0] wresp, wresp2;
  logic [3:0] wid, wid2;
  int lat, lat2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld_rdy", 32'({awready, wready, bvalid, arready, rvalid}), 32'h0);
    chk("rst_outs", 32'({bresp, bid, rresp, rlast, rid}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", 32'({awready, arready}), 32'h3);

    // Single write then read
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(32'h0f00_0010, 4'd3, 8'd0, 2'b01, -1, wresp, wid);
    chk("single_bresp", 32'(wresp), 32'h0);
    chk("single_bid", 32'(wid), 32'h3);
    do_read(32'h0f00_0010, 4'd5, 8'd0, 1'b0, lat);
    chk("single_rdata", rd_dat[0], 32'hDEADBEEF);
    chk("single_rresp", 32'(rd_resp[0]), 32'h0);
    chk("single_rlast", 32'(rd_last[0]), 32'h1);
    chk("single_rid", 32'(rd_id[0]), 32'h5);
    chk("first_latency", 32'(lat), 32'(LAT_EXP));

    // Strobed write
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(32'h0f00_0020, 4'd1, 8'd0, 2'b01, -1, wresp, wid);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    do_write(32'h0f00_0020, 4'd1, 8'd0, 2'b01, -1, wresp, wid);
    do_read(32'h0f00_0020, 4'd2, 8'd0, 1'b0, lat);
    chk("strobe_rdata", rd_dat[0], 32'h11BB33DD);

    // INCR burst with rready toggling on readback
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(32'h0f00_0100, 4'd7, 8'd3, 2'b01, -1, wresp, wid);
    chk("incr_bresp", 32'(wresp), 32'h0);
    do_read(32'h0f00_0100, 4'd9, 8'd3, 1'b1, lat);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rdata%0d", i), rd_dat[i], 32'(i + 1));
      chk($sformatf("incr_rlast%0d", i), 32'(rd_last[i]), (i == 3) ? 32'h1 : 32'h0);
    end
    chk("incr_rid", 32'(rd_id[3]), 32'h9);

    // Out-of-range read
    do_read(32'h0f00_1000, 4'd4, 8'd0, 1'b0, lat);
    chk("oor_rresp", 32'(rd_resp[0]), 32'h2);
    chk("oor_rdata", rd_dat[0], 32'h0);

    // WRAP write leaves memory untouched
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    do_write(32'h0f00_0010, 4'd6, 8'd0, 2'b10, -1, wresp, wid);
    chk("wrap_bresp", 32'(wresp), 32'h2);
    do_read(32'h0f00_0010, 4'd6, 8'd0, 1'b0, lat);
    chk("wrap_unchanged", rd_dat[0], 32'hDEADBEEF);

    // Early wlast: both beats accepted, SLVERR
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(32'h0f00_0300, 4'd2, 8'd1, 2'b01, 0, wresp, wid);
    chk("early_wlast_bresp", 32'(wresp), 32'h2);

    // Concurrent read and write bursts started together
    wbuf[0] = 32'h55; wbuf[1] = 32'h66; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    fork
      do_write(32'h0f00_0200, 4'd8, 8'd1, 2'b01, -1, wresp2, wid2);
      do_read(32'h0f00_0100, 4'd10, 8'd3, 1'b0, lat2);
    join
    chk("conc_bresp", 32'(wresp2), 32'h0);
    chk("conc_bid", 32'(wid2), 32'h8);
    for (int i = 0; i < 4; i++) chk($sformatf("conc_rdata%0d", i), rd_dat[i], 32'(i + 1));
    do_read(32'h0f00_0200, 4'd11, 8'd1, 1'b0, lat);
    chk("conc_wr0", rd_dat[0], 32'h55);
    chk("conc_wr1", rd_dat[1], 32'h66);

    // Reset in the middle of a read burst
    araddr = 32'h0f00_0100; arid = 4'd1; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b0;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < TMO);
      chk("mid_ar_ready", 32'(arready), 32'h1);
      @(posedge clk); #1 arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rvalid && n < TMO);
      chk("mid_rvalid", 32'(rvalid), 32'h1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(32'h0f00_0010, 4'd12, 8'd0, 1'b0, lat);
    chk("after_rst_rdata", rd_dat[0], 32'hDEADBEEF);
    chk("after_rst_rid", 32'(rd_id[0]), 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
